tdm_transmission: RTL and testbench
===================================

TDM_TRANSMISSION -- requirements
Module: tdm_transmission

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning bits per channel word.
REQ-002 The block SHALL have parameter SEL_W, default 3, meaning channel-select width; channel count CH = 2**SEL_W.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port iStart  input  1  frame request, sampled only in IDLE.
REQ-006 Port iMode  input  1  0 = scan all channels, 1 = single channel; sampled with iStart.
REQ-007 Port iSel  input  SEL_W  channel for single mode; sampled with iStart.
REQ-008 Port iData  input  CH*WIDTH  parallel source; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port oBusy  output  1  high while a frame is in progress (SEND or DONE).
REQ-010 Port oValid  output  1  oWord/oChan carry a transmitted word this cycle.
REQ-011 Port oChan  output  SEL_W  channel index of oWord.
REQ-012 Port oWord  output  WIDTH  serialised channel word.
REQ-013 Port oData  output  CH*WIDTH  demultiplexed destination bank, same slicing as iData.
REQ-014 Port oDone  output  1  high for exactly one cycle, coinciding with the last word of a frame.

Function
REQ-015 FSM states SHALL be IDLE, SEND, DONE; state register is the only source of oBusy and oDone (oBusy = SEND|DONE, oDone = DONE).
REQ-016 IDLE with iStart=1 at edge E0 SHALL: copy iData into a CH*WIDTH shadow register, latch iMode, load slot counter with 0 (scan) or iSel (single), go to SEND.
REQ-017 iStart SHALL be ignored in SEND and DONE; no queuing of requests.
REQ-018 Each edge in SEND SHALL register oValid=1, oChan=counter, oWord=shadow[counter], and write shadow[counter] into oData slice counter; other oData slices hold.
REQ-019 Scan mode SHALL emit channels 0..CH-1 in ascending order on edges E1..E_CH, one per cycle, no gaps; counter increments by 1 per word.
REQ-020 Single mode SHALL emit exactly one word (channel iSel as latched) on edge E1.
REQ-021 The edge that emits the last word SHALL move state to DONE; during DONE, oValid=1 with the last word and oDone=1.
REQ-022 The edge leaving DONE SHALL set state IDLE, oValid=0; oChan/oWord hold last values.
REQ-023 Latency: first word visible 1 cycle after the iStart sampling edge; frame occupies CH cycles (scan) or 1 cycle (single) of oValid; earliest next iStart accepted one cycle after oDone.
REQ-024 iData, iMode, iSel changes after E0 SHALL NOT affect the frame in progress.
REQ-025 Counter SHALL be SEL_W bits; no wrap occurs within a frame; with iSel=CH-1 in single mode, behaviour is identical to any other channel.
REQ-026 oData SHALL retain its contents between frames; only transmitted slices are overwritten.

Reset
REQ-027 rst_n=0 SHALL immediately (without clock) force state IDLE, counter 0, shadow 0, oValid 0, oChan 0, oWord 0, oData 0; hence oBusy 0, oDone 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; no partial oDone; after release the block waits in IDLE for a new iStart.
REQ-029 iStart high on the first edge after rst_n release SHALL be accepted normally.

Verification (WIDTH=8, SEL_W=3; channel k of iData = 8'hA0+k unless stated)
REQ-030 Scan: iStart=1, iMode=0 for one cycle -> next 8 cycles oValid=1, oChan 0..7, oWord A0..A7; oDone=1 only with oChan=7; then oData = {A7,...,A0}, oBusy=0.
REQ-031 Single: iMode=1, iSel=5, iStart pulse -> one cycle oValid=1, oChan=5, oWord=A5, oDone=1; only oData slice 5 changes (others stay 0 after reset).
REQ-032 Shadow: start scan, then set iData all channels to 8'h55 on cycle 2 -> all 8 words still A0..A7.
REQ-033 Busy ignore: hold iStart=1 continuously in scan mode -> frames separated by exactly one oValid=0 IDLE cycle; no frame restarts while oBusy=1.
REQ-034 Reset mid-frame: deassert rst_n asynchronously after oChan=3 -> all outputs 0 without clock edge; no oDone; after release, single-mode frame on iSel=0 gives oWord=A0.
REQ-035 Pattern: iData = 8'b10101010 in every channel, scan -> every oWord = 8'hAA, oData = 64'hAAAA_AAAA_AAAA_AAAA.

Source files
------------

// File: rtl/tdm_transmission.sv
// -----------------------------------------------------------------------------
// tdm_transmission
//
// Time-division multiplexed transmitter with a local demultiplexing bank.
// A frame request captures the parallel source iData into a shadow register.
// The block then serialises the captured channel words one per clock, either
// all CH channels in ascending order (scan mode) or one selected channel
// (single mode). Every transmitted word is also written into the matching
// slice of the destination bank oData. Slices that are not transmitted keep
// their previous contents.
//
// Parameters
//   WIDTH   bits per channel word
//   SEL_W   channel-select width, channel count CH = 2**SEL_W
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   iStart  frame request, only looked at while idle
//   iMode   0 = scan all channels, 1 = single channel (sampled with iStart)
//   iSel    channel used in single mode (sampled with iStart)
//   iData   parallel source, channel k at [k*WIDTH +: WIDTH]
//   oBusy   frame in progress (SEND or DONE)
//   oValid  oWord/oChan carry a transmitted word
//   oChan   channel index of oWord
//   oWord   serialised channel word
//   oData   destination bank, same slicing as iData
//   oDone   one-cycle pulse alongside the last word of a frame
// -----------------------------------------------------------------------------
module tdm_transmission #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            iStart,
    input  logic                            iMode,
    input  logic [SEL_W-1:0]                iSel,
    input  logic [(2**SEL_W)*WIDTH-1:0]     iData,
    output logic                            oBusy,
    output logic                            oValid,
    output logic [SEL_W-1:0]                oChan,
    output logic [WIDTH-1:0]                oWord,
    output logic [(2**SEL_W)*WIDTH-1:0]     oData,
    output logic                            oDone
);

    localparam int CH    = 2**SEL_W;
    localparam int TOTAL = CH * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   slotCnt;
    logic               modeReg;
    logic [TOTAL-1:0]   shadow;

    logic               lastSlot;
    logic [WIDTH-1:0]   curWord;

    // Word currently addressed by the slot counter in the captured frame.
    always_comb begin
        curWord = shadow[slotCnt*WIDTH +: WIDTH];
    end

    // The word being emitted ends the frame in single mode, or on the top
    // channel in scan mode; the counter therefore never wraps inside a frame.
    always_comb begin
        lastSlot = 1'b0;
        if (modeReg) begin
            lastSlot = 1'b1;
        end else if (slotCnt == SEL_W'(CH - 1)) begin
            lastSlot = 1'b1;
        end else begin
            lastSlot = 1'b0;
        end
    end

    // Status flags are pure decodes of the state register.
    always_comb begin
        oBusy = 1'b0;
        oDone = 1'b0;
        if (state == SEND) begin
            oBusy = 1'b1;
        end else if (state == DONE) begin
            oBusy = 1'b1;
            oDone = 1'b1;
        end else begin
            oBusy = 1'b0;
            oDone = 1'b0;
        end
    end

    // Frame controller: capture, serialise, demultiplex, registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            slotCnt <= {SEL_W{1'b0}};
            modeReg <= 1'b0;
            shadow  <= {TOTAL{1'b0}};
            oValid  <= 1'b0;
            oChan   <= {SEL_W{1'b0}};
            oWord   <= {WIDTH{1'b0}};
            oData   <= {TOTAL{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    oValid <= 1'b0;
                    if (iStart) begin
                        // Everything the frame depends on is frozen here so
                        // later input changes cannot disturb it.
                        shadow  <= iData;
                        modeReg <= iMode;
                        slotCnt <= iMode ? iSel : {SEL_W{1'b0}};
                        state   <= SEND;
                    end
                end
                SEND: begin
                    oValid <= 1'b1;
                    oChan  <= slotCnt;
                    oWord  <= curWord;
                    oData[slotCnt*WIDTH +: WIDTH] <= curWord;
                    if (lastSlot) begin
                        state <= DONE;
                    end else begin
                        slotCnt <= slotCnt + SEL_W'(1);
                    end
                end
                DONE: begin
                    // The last word stays valid for this one cycle; oChan and
                    // oWord keep their values after leaving.
                    oValid <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    oValid <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_transmission.sv
// Directed bench for tdm_transmission with WIDTH=8, SEL_W=3.
module tb_tdm_transmission;

    localparam int WIDTH = 8;
    localparam int SEL_W = 3;
    localparam int CH    = 8;

    logic               clk;
    logic               rst_n;
    logic               iStart;
    logic               iMode;
    logic [SEL_W-1:0]   iSel;
    logic [63:0]        iData;
    logic               oBusy;
    logic               oValid;
    logic [SEL_W-1:0]   oChan;
    logic [WIDTH-1:0]   oWord;
    logic [63:0]        oData;
    logic               oDone;

    int nCmp;
    int nFail;

    tdm_transmission #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .iStart (iStart),
        .iMode  (iMode),
        .iSel   (iSel),
        .iData  (iData),
        .oBusy  (oBusy),
        .oValid (oValid),
        .oChan  (oChan),
        .oWord  (oWord),
        .oData  (oData),
        .oDone  (oDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadRamp();
        for (int k = 0; k < CH; k++) iData[k*8 +: 8] = 8'hA0 + 8'(k);
    endtask

    initial begin
        nCmp  = 0;
        nFail = 0;
        rst_n  = 1'b1;
        iStart = 1'b0;
        iMode  = 1'b0;
        iSel   = 3'd0;
        loadRamp();

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(oValid), 64'd0);
        chk("rst_busy",  64'(oBusy),  64'd0);
        chk("rst_done",  64'(oDone),  64'd0);
        chk("rst_chan",  64'(oChan),  64'd0);
        chk("rst_word",  64'(oWord),  64'd0);
        chk("rst_data",  oData,       64'd0);
        tick();
        tick();

        // Single mode on channel 5, requested on the first edge after release.
        rst_n  = 1'b1;
        iStart = 1'b1;
        iMode  = 1'b1;
        iSel   = 3'd5;
        tick();
        iStart = 1'b0;
        chk("single_e0_busy",  64'(oBusy),  64'd1);
        chk("single_e0_valid", 64'(oValid), 64'd0);
        tick();
        chk("single_valid", 64'(oValid), 64'd1);
        chk("single_chan",  64'(oChan),  64'd5);
        chk("single_word",  64'(oWord),  64'hA5);
        chk("single_done",  64'(oDone),  64'd1);
        chk("single_data",  oData,       64'h0000_A500_0000_0000);
        tick();
        chk("single_end_valid", 64'(oValid), 64'd0);
        chk("single_end_busy",  64'(oBusy),  64'd0);
        chk("single_end_done",  64'(oDone),  64'd0);
        chk("single_hold_chan", 64'(oChan),  64'd5);
        chk("single_hold_word", 64'(oWord),  64'hA5);

        // Scan frame; source and mode inputs change after the request edge.
        iMode  = 1'b0;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int i = 0; i < CH; i++) begin
            tick();
            if (i == 0) begin
                iData = 64'h5555_5555_5555_5555;
                iMode = 1'b1;
                iSel  = 3'd2;
            end
            chk("scan_valid", 64'(oValid), 64'd1);
            chk("scan_chan",  64'(oChan),  64'(i));
            chk("scan_word",  64'(oWord),  64'(8'hA0 + 8'(i)));
            chk("scan_done",  64'(oDone),  (i == CH-1) ? 64'd1 : 64'd0);
            chk("scan_busy",  64'(oBusy),  64'd1);
        end
        chk("scan_data", oData, 64'hA7A6_A5A4_A3A2_A1A0);
        tick();
        chk("scan_end_valid", 64'(oValid), 64'd0);
        chk("scan_end_busy",  64'(oBusy),  64'd0);
        loadRamp();
        iMode = 1'b0;
        iSel  = 3'd0;

        // iStart held high: back-to-back frames with one idle cycle between.
        iStart = 1'b1;
        tick();
        for (int i = 0; i < CH; i++) begin
            tick();
            chk("hold_chan", 64'(oChan), 64'(i));
            chk("hold_busy", 64'(oBusy), 64'd1);
        end
        tick();
        chk("hold_idle_busy",  64'(oBusy),  64'd0);
        chk("hold_idle_valid", 64'(oValid), 64'd0);
        tick();
        chk("hold_restart_busy",  64'(oBusy),  64'd1);
        chk("hold_restart_valid", 64'(oValid), 64'd0);
        tick();
        iStart = 1'b0;
        chk("hold_f2_chan",  64'(oChan),  64'd0);
        chk("hold_f2_valid", 64'(oValid), 64'd1);
        for (int i = 1; i < CH; i++) tick();
        chk("hold_f2_last", 64'(oChan), 64'd7);
        chk("hold_f2_done", 64'(oDone), 64'd1);
        tick();

        // Asynchronous reset in the middle of a scan frame.
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_chan3", 64'(oChan), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(oValid), 64'd0);
        chk("mid_rst_busy",  64'(oBusy),  64'd0);
        chk("mid_rst_done",  64'(oDone),  64'd0);
        chk("mid_rst_chan",  64'(oChan),  64'd0);
        chk("mid_rst_word",  64'(oWord),  64'd0);
        chk("mid_rst_data",  oData,       64'd0);
        tick();
        chk("mid_rst_done2", 64'(oDone), 64'd0);
        rst_n  = 1'b1;
        iStart = 1'b1;
        iMode  = 1'b1;
        iSel   = 3'd0;
        tick();
        iStart = 1'b0;
        tick();
        chk("post_rst_word", 64'(oWord), 64'hA0);
        chk("post_rst_chan", 64'(oChan), 64'd0);
        chk("post_rst_done", 64'(oDone), 64'd1);
        chk("post_rst_data", oData,      64'h0000_0000_0000_00A0);
        tick();

        // Single mode on the top channel.
        iStart = 1'b1;
        iSel   = 3'd7;
        tick();
        iStart = 1'b0;
        tick();
        chk("top_chan", 64'(oChan), 64'd7);
        chk("top_word", 64'(oWord), 64'hA7);
        chk("top_done", 64'(oDone), 64'd1);
        chk("top_data", oData,      64'hA700_0000_0000_00A0);
        tick();
        chk("top_end_busy", 64'(oBusy), 64'd0);

        // Alternating bit pattern in every channel.
        iData  = 64'hAAAA_AAAA_AAAA_AAAA;
        iMode  = 1'b0;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int i = 0; i < CH; i++) begin
            tick();
            chk("pat_word", 64'(oWord), 64'hAA);
        end
        chk("pat_data", oData, 64'hAAAA_AAAA_AAAA_AAAA);
        tick();
        chk("pat_end_busy", 64'(oBusy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
